// File: rtl/param_pipe_reg_pkg.sv
// rtl/param_pipe_reg_pkg.sv - shared types and helpers for the param_pipe_reg slice
//
// Package param_pipe_pkg:
//   count_width(depth) : occupancy counter width, $clog2(depth+2); also covers the
//                        extra skid entry when that option is built in
//   RST_BIT            : reset value of every data bit (data resets to all zeros)
//   pipe_stage_t       : valid+data view of one 8-bit stage for SV users
package param_pipe_pkg;

  localparam logic RST_BIT = 1'b0;

  typedef struct packed {
    logic       vld;
    logic [7:0] dat;
  } pipe_stage_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/param_pipe_reg_if.sv
// rtl/param_pipe_reg_if.sv - valid/ready stream bundle for param_pipe_reg
//
// Parameter: W data width.
// Signals  : in_valid/in_ready/d_in (upstream side), out_valid/out_ready/d_out
//            (downstream side).
// Modports : master = environment driving the pipe, slave = the pipe itself.
interface param_pipe_reg_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] d_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d_out;

  modport master (
    output in_valid, d_in, out_ready,
    input  in_ready, out_valid, d_out
  );

  modport slave (
    input  in_valid, d_in, out_ready,
    output in_ready, out_valid, d_out
  );
endinterface

// File: rtl/param_pipe_reg_stage.sv
// rtl/param_pipe_reg_stage.sv - one valid/data register stage of the pipeline
//
// Module pipe_stage:
//   clk, resetn : clock, asynchronous active-low reset (vld and dat to zero)
//   i_clr       : synchronous flush of vld (data left as is)
//   i_load      : capture i_vld this cycle; dat only follows when i_vld is set
//   i_vld/i_dat : incoming valid/data
//   o_vld/o_dat : registered valid/data
module pipe_stage
  import param_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic         i_vld,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);

  logic         r_vld;
  logic [W-1:0] r_dat;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld <= 1'b0;
      r_dat <= {W{RST_BIT}};
    end else if (i_clr) begin
      r_vld <= 1'b0;
    end else if (i_load) begin
      r_vld <= i_vld;
      // Empty stages keep stale data; only real words overwrite it.
      if (i_vld) r_dat <= i_dat;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/param_pipe_reg.sv
// rtl/param_pipe_reg.sv - DEPTH-stage valid/ready register pipeline with flush and occupancy
//
// Parameters: W data width, DEPTH stage count, CW count width (derived).
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   clr         : synchronous flush of all stages (and skid), drops any concurrent push/pop
//   bus         : param_pipe_reg_if slave (in_valid/in_ready/d_in, out_valid/out_ready/d_out)
//   count       : registered number of valid entries held
// Build option PARAM_PIPE_REG_SKID_EN: adds a skid register ahead of stage 0 so
// in_ready comes straight from a flop; capacity grows to DEPTH+1.
module param_pipe_reg
  import param_pipe_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = count_width(DEPTH)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clr,
  param_pipe_reg_if.slave bus,
  output logic [CW-1:0]   count
);

  logic [DEPTH-1:0] w_vld;
  logic [DEPTH-1:0] w_ld;
  logic [W-1:0]     w_dat [DEPTH];
  logic             w_s0_vld;
  logic [W-1:0]     w_s0_dat;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    r_count;

  // Stage i may load when it is empty or when every stage from i to the output
  // is full and the output is popping; i.e. anything empty at or after i lets
  // the words behind it compact forward.
  always_comb begin : p_load
    logic w_tail_full;
    w_tail_full = 1'b1;
    w_ld        = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_tail_full = w_tail_full & w_vld[i];
      w_ld[i]     = bus.out_ready | !w_tail_full;
    end
  end

`ifdef PARAM_PIPE_REG_SKID_EN
  logic         w_skid_vld;
  logic [W-1:0] w_skid_dat;
  logic         w_skid_load;
  logic         w_skid_nvld;

  assign bus.in_ready = !w_skid_vld;
  assign w_push       = bus.in_valid & bus.in_ready;
  // A full skid only ever drains (no push can land while it is full); an empty
  // skid captures a pushed word that stage 0 cannot take this cycle.
  assign w_skid_load  = w_skid_vld ? w_ld[0] : (w_push & !w_ld[0]);
  assign w_skid_nvld  = !w_skid_vld;
  assign w_s0_vld     = w_skid_vld | w_push;
  assign w_s0_dat     = w_skid_vld ? w_skid_dat : bus.d_in;

  pipe_stage #(.W(W)) u_skid (
    .clk    (clk),
    .resetn (resetn),
    .i_clr  (clr),
    .i_load (w_skid_load),
    .i_vld  (w_skid_nvld),
    .i_dat  (bus.d_in),
    .o_vld  (w_skid_vld),
    .o_dat  (w_skid_dat)
  );
`else
  assign bus.in_ready = w_ld[0];
  assign w_push       = bus.in_valid & bus.in_ready;
  assign w_s0_vld     = w_push;
  assign w_s0_dat     = bus.d_in;
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic         w_src_vld;
    logic [W-1:0] w_src_dat;

    if (g == 0) begin : g_first
      assign w_src_vld = w_s0_vld;
      assign w_src_dat = w_s0_dat;
    end else begin : g_next
      assign w_src_vld = w_vld[g-1];
      assign w_src_dat = w_dat[g-1];
    end

    pipe_stage #(.W(W)) u_stage (
      .clk    (clk),
      .resetn (resetn),
      .i_clr  (clr),
      .i_load (w_ld[g]),
      .i_vld  (w_src_vld),
      .i_dat  (w_src_dat),
      .o_vld  (w_vld[g]),
      .o_dat  (w_dat[g])
    );
  end

  assign w_pop         = w_vld[DEPTH-1] & bus.out_ready;
  assign bus.out_valid = w_vld[DEPTH-1];
  assign bus.d_out     = w_dat[DEPTH-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_param_pipe_reg.sv
// tb/tb_param_pipe_reg.sv - directed and random self-checking bench for param_pipe_reg
module tb_param_pipe_reg;
  import param_pipe_pkg::*;

`ifdef PARAM_PIPE_REG_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic clr    = 1'b0;
  int   tests  = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  param_pipe_reg_if #(.W(8))  b3 ();
  param_pipe_reg_if #(.W(8))  b2 ();
  param_pipe_reg_if #(.W(16)) b1 ();
  param_pipe_reg_if #(.W(16)) b4 ();

  logic [count_width(3)-1:0] cnt3;
  logic [count_width(2)-1:0] cnt2;
  logic [count_width(1)-1:0] cnt1;
  logic [count_width(4)-1:0] cnt4;

  param_pipe_reg #(.W(8),  .DEPTH(3)) u3 (.clk(clk), .resetn(resetn), .clr(clr), .bus(b3), .count(cnt3));
  param_pipe_reg #(.W(8),  .DEPTH(2)) u2 (.clk(clk), .resetn(resetn), .clr(clr), .bus(b2), .count(cnt2));
  param_pipe_reg #(.W(16), .DEPTH(1)) u1 (.clk(clk), .resetn(resetn), .clr(clr), .bus(b1), .count(cnt1));
  param_pipe_reg #(.W(16), .DEPTH(4)) u4 (.clk(clk), .resetn(resetn), .clr(clr), .bus(b4), .count(cnt4));

  task automatic idle_inputs();
    b3.in_valid = 0; b3.d_in = '0; b3.out_ready = 0;
    b2.in_valid = 0; b2.d_in = '0; b2.out_ready = 0;
    b1.in_valid = 0; b1.d_in = '0; b1.out_ready = 0;
    b4.in_valid = 0; b4.d_in = '0; b4.out_ready = 0;
    clr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    idle_inputs();
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (b3.out_valid !== 1'b0 || cnt3 !== 0 || b3.d_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_init out_valid=%b count=%0d d_out=%h required 0/0/00", b3.out_valid, cnt3, b3.d_out);
    end
    @(negedge clk);
    resetn = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      b3.out_ready = 0;
      b3.in_valid  = (c < 2);
      b3.d_in      = (c == 0) ? 8'h11 : 8'h22;
    end
    #1;
    tests++;
    if (b3.out_valid !== 1'b1 || b3.d_out !== 8'h11 || cnt3 !== 2) begin
      fails++;
      $display("FAIL reset_preload out_valid=%b d_out=%h count=%0d required 1/11/2", b3.out_valid, b3.d_out, cnt3);
    end
    #2;
    resetn = 0;
    #1;
    tests++;
    if (b3.out_valid !== 1'b0 || cnt3 !== 0 || b3.d_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_async out_valid=%b count=%0d d_out=%h required 0/0/00", b3.out_valid, cnt3, b3.d_out);
    end
    @(negedge clk);
    resetn = 1;
    b3.in_valid = 1; b3.d_in = 8'hA5; b3.out_ready = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      b3.in_valid = 0;
      #1;
      tests++;
      if (c == 3) begin
        if (b3.out_valid !== 1'b1 || b3.d_out !== 8'hA5) begin
          fails++;
          $display("FAIL reset_first_push c=%0d out_valid=%b d_out=%h required 1/a5", c, b3.out_valid, b3.d_out);
        end
      end else if (b3.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_first_push c=%0d out_valid=%b required 0", c, b3.out_valid);
      end
    end
  endtask

  task automatic test_streaming();
    int exp_cnt;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      b3.out_ready = 1;
      b3.in_valid  = (c < 16);
      b3.d_in      = 8'(c + 1);
      #1;
      if (c < 16) begin
        tests++;
        if (b3.in_ready !== 1'b1) begin
          fails++;
          $display("FAIL stream_in_ready c=%0d got %b required 1", c, b3.in_ready);
        end
      end
      tests++;
      if (c >= 3 && c < 19) begin
        if (b3.out_valid !== 1'b1 || b3.d_out !== 8'(c - 2)) begin
          fails++;
          $display("FAIL stream_out c=%0d out_valid=%b d_out=%h required 1/%h", c, b3.out_valid, b3.d_out, 8'(c - 2));
        end
      end else if (b3.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL stream_out c=%0d out_valid=%b required 0", c, b3.out_valid);
      end
      exp_cnt = ((c < 16) ? c : 16) - ((c < 3) ? 0 : (((c < 19) ? c : 19) - 3));
      tests++;
      if (cnt3 !== exp_cnt) begin
        fails++;
        $display("FAIL stream_count c=%0d got %0d required %0d", c, cnt3, exp_cnt);
      end
    end
  endtask

  task automatic test_back_pressure();
    int acc;
    acc = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      b3.out_ready = 0;
      b3.in_valid  = 1;
      b3.d_in      = 8'(8'h40 + acc);
      #1;
      if (!b3.in_ready) break;
      acc++;
    end
    b3.in_valid = 0;
    tests++;
    if (acc !== 3 + SKID || cnt3 !== 3 + SKID) begin
      fails++;
      $display("FAIL fill_capacity accepted=%0d count=%0d required %0d", acc, cnt3, 3 + SKID);
    end
    for (int k = 0; k < 3 + SKID; k++) begin
      @(negedge clk);
      b3.out_ready = 1;
      #1;
      tests++;
      if (b3.out_valid !== 1'b1 || b3.d_out !== 8'(8'h40 + k) || cnt3 !== 3 + SKID - k) begin
        fails++;
        $display("FAIL drain k=%0d out_valid=%b d_out=%h count=%0d required 1/%h/%0d",
                 k, b3.out_valid, b3.d_out, cnt3, 8'(8'h40 + k), 3 + SKID - k);
      end
    end
    @(negedge clk);
    #1;
    tests++;
    if (b3.out_valid !== 1'b0 || cnt3 !== 0) begin
      fails++;
      $display("FAIL drain_empty out_valid=%b count=%0d required 0/0", b3.out_valid, cnt3);
    end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] din   [5] = '{8'h50, 8'h51, 8'h60, 8'h61, 8'h62};
    logic [7:0] exp_d [8] = '{8'h00, 8'h00, 8'h50, 8'h51, 8'h60, 8'h61, 8'h62, 8'h00};
    int         exp_n [8] = '{0, 1, 2, 2, 2, 2, 1, 0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      b2.in_valid  = (c < 5);
      b2.d_in      = (c < 5) ? din[c] : 8'h00;
      b2.out_ready = (c >= 2);
      #1;
      if (c < 5) begin
        tests++;
        if (b2.in_ready !== 1'b1) begin
          fails++;
          $display("FAIL full_in_ready c=%0d got %b required 1", c, b2.in_ready);
        end
      end
      tests++;
      if (c >= 2 && c <= 6) begin
        if (b2.out_valid !== 1'b1 || b2.d_out !== exp_d[c]) begin
          fails++;
          $display("FAIL full_out c=%0d out_valid=%b d_out=%h required 1/%h", c, b2.out_valid, b2.d_out, exp_d[c]);
        end
      end else if (b2.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL full_out c=%0d out_valid=%b required 0", c, b2.out_valid);
      end
      tests++;
      if (cnt2 !== exp_n[c]) begin
        fails++;
        $display("FAIL full_count c=%0d got %0d required %0d", c, cnt2, exp_n[c]);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      clr          = (c == 2);
      b3.in_valid  = (c <= 3);
      b3.d_in      = (c == 0) ? 8'h71 : (c == 1) ? 8'h72 : (c == 2) ? 8'h73 : 8'h3C;
      b3.out_ready = (c >= 3);
      #1;
      if (c == 2) begin
        tests++;
        if (b3.in_ready !== 1'b1 || cnt3 !== 2) begin
          fails++;
          $display("FAIL flush_pre in_ready=%b count=%0d required 1/2", b3.in_ready, cnt3);
        end
      end
      if (c >= 3 && c <= 5) begin
        tests++;
        if (b3.out_valid !== 1'b0 || cnt3 !== ((c == 3) ? 0 : 1)) begin
          fails++;
          $display("FAIL flush_post c=%0d out_valid=%b count=%0d required 0/%0d", c, b3.out_valid, cnt3, (c == 3) ? 0 : 1);
        end
      end
      if (c == 6) begin
        tests++;
        if (b3.out_valid !== 1'b1 || b3.d_out !== 8'h3C || cnt3 !== 1) begin
          fails++;
          $display("FAIL flush_next out_valid=%b d_out=%h count=%0d required 1/3c/1", b3.out_valid, b3.d_out, cnt3);
        end
      end
    end
    clr = 0;
  endtask

  task automatic test_random();
    logic [15:0] q1 [$];
    logic [15:0] q4 [$];
    logic        rdy1, rdy4;
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      b1.in_valid  = 1'($urandom_range(0, 1));
      b1.d_in      = 16'($urandom);
      b1.out_ready = 1'($urandom_range(0, 1));
      b4.in_valid  = 1'($urandom_range(0, 1));
      b4.d_in      = 16'($urandom);
      b4.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      rdy1 = SKID ? (q1.size() <= 1) : (q1.size() < 1 || b1.out_ready);
      rdy4 = SKID ? (q4.size() <= 4) : (q4.size() < 4 || b4.out_ready);
      tests++;
      if (cnt1 !== q1.size() || b1.in_ready !== rdy1) begin
        fails++;
        $display("FAIL rand_d1 n=%0d count=%0d in_ready=%b required %0d/%b", n, cnt1, b1.in_ready, q1.size(), rdy1);
      end
      tests++;
      if (cnt4 !== q4.size() || b4.in_ready !== rdy4) begin
        fails++;
        $display("FAIL rand_d4 n=%0d count=%0d in_ready=%b required %0d/%b", n, cnt4, b4.in_ready, q4.size(), rdy4);
      end
      if (b1.out_valid) begin
        tests++;
        if (q1.size() == 0 || b1.d_out !== q1[0]) begin
          fails++;
          $display("FAIL rand_d1_data n=%0d d_out=%h required %h", n, b1.d_out, (q1.size() != 0) ? q1[0] : 16'hxxxx);
        end
        if (b1.out_ready && q1.size() != 0) void'(q1.pop_front());
      end
      if (b4.out_valid) begin
        tests++;
        if (q4.size() == 0 || b4.d_out !== q4[0]) begin
          fails++;
          $display("FAIL rand_d4_data n=%0d d_out=%h required %h", n, b4.d_out, (q4.size() != 0) ? q4[0] : 16'hxxxx);
        end
        if (b4.out_ready && q4.size() != 0) void'(q4.pop_front());
      end
      if (b1.in_valid && rdy1) q1.push_back(b1.d_in);
      if (b4.in_valid && rdy4) q4.push_back(b4.d_in);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_push_pop_full();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
